// File: rtl/vend_credit_ctrl_pkg.sv
// Shared definitions for the vending credit controller.
//   State encodings (also driven out on the state port), coin codes and the
//   coin-code -> credit-unit conversion. Unknown coin codes are worth 0 units,
//   so they are treated as "no coin".
package vend_credit_ctrl_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_VEND    = 3'd2;
   localparam logic [2:0] ST_REFUND  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [2:0] COIN_1 = 3'b001;
   localparam logic [2:0] COIN_2 = 3'b010;
   localparam logic [2:0] COIN_5 = 3'b100;

   function automatic logic [2:0] coin_val(input logic [2:0] code);
      case (code)
         COIN_1:  return 3'd1;
         COIN_2:  return 3'd2;
         COIN_5:  return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_credit_ctrl_timer.sv
// Loadable down-counter with terminal-count compare.
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset (count cleared)
//   load     in   load load_val this cycle (wins over counting)
//   load_val in   W-bit reload value
//   expire   out  high for the single cycle in which count == 1
// A load of N gives expire N-1 cycles after the loading edge is seen,
// i.e. the edge that ends the expire cycle is the N-th edge after loading.
module vend_credit_ctrl_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign expire = (count == W'(1));

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit/timing sequencer for the drink vending FSM: accumulates coin value,
// gates purchase against PRICE, times the inactivity and pickup windows and
// sequences dispense and coin-by-coin change. All outputs are registered.
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   coin         in   coin code 001=1, 010=2, 100=5 units, others = no coin
//   press        in   purchase button (level)
//   cancel_flag  in   cancel request (level)
//   timeout      out  1-cycle pulse to the vending FSM
//   dispense     out  1-cycle pulse, release one drink
//   change_pulse out  1-cycle pulse per credit unit returned
//   coin_reject  out  1-cycle pulse, coin not accepted
//   credit       out  current credit
//   busy         out  high in VEND/REFUND/DONE
//   state        out  current state encoding
// Build option: VEND_INPUT_SYNC_EN adds a 2-flop synchronizer on coin, press
// and cancel_flag (all responses move 2 cycles later).
//
// state    | meaning
// IDLE     | no credit, waiting for the first coin
// COLLECT  | accepting coins, inactivity window running
// VEND     | one cycle, drink released, price taken from credit
// REFUND   | returning remaining credit one unit per change_pulse
// DONE     | pickup window; timeout on its last cycle, then IDLE
module vend_credit_ctrl
   import vend_credit_ctrl_pkg::*;
#(
   parameter int PRICE       = 5,
   parameter int CREDIT_W    = 4,
   parameter int TIMEOUT_CYC = 20,
   parameter int CHANGE_CYC  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          coin,
   input  logic                press,
   input  logic                cancel_flag,
   output logic                timeout,
   output logic                dispense,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic [2:0]          state
);

   localparam int T_MAX = (TIMEOUT_CYC > CHANGE_CYC) ? TIMEOUT_CYC : CHANGE_CYC;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam int CW1   = CREDIT_W + 1;
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   logic [2:0] coin_s;
   logic       press_s;
   logic       cancel_s;

`ifdef VEND_INPUT_SYNC_EN
   logic [4:0] sync_q1;
   logic [4:0] sync_q2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {coin, press, cancel_flag};
         sync_q2 <= sync_q1;
      end
   end

   assign {coin_s, press_s, cancel_s} = sync_q2;
`else
   assign coin_s   = coin;
   assign press_s  = press;
   assign cancel_s = cancel_flag;
`endif

   logic [2:0]          coin_units;
   logic                coin_prev;
   logic                coin_evt;
   logic [CW1-1:0]      credit_sum;

   assign coin_units = coin_val(coin_s);
   // a held coin is only counted on its first valid cycle
   assign coin_evt   = (coin_units != 3'd0) && !coin_prev;
   // carry out of the credit width means the coin would overflow credit
   assign credit_sum = {1'b0, credit} + CW1'(coin_units);

   logic           win_load, win_expire;
   logic [T_W-1:0] win_val;
   logic           chg_load, chg_expire;
   logic [T_W-1:0] chg_val;

   vend_credit_ctrl_timer #(.W(T_W)) u_win_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (win_load),
      .load_val (win_val),
      .expire   (win_expire)
   );

   vend_credit_ctrl_timer #(.W(T_W)) u_chg_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (chg_load),
      .load_val (chg_val),
      .expire   (chg_expire)
   );

   logic [2:0]          state_nx;
   logic [CREDIT_W-1:0] credit_nx;
   logic                timeout_nx, dispense_nx, change_nx, reject_nx, busy_nx;

   always_comb begin
      state_nx    = state;
      credit_nx   = credit;
      timeout_nx  = 1'b0;
      dispense_nx = 1'b0;
      change_nx   = 1'b0;
      reject_nx   = 1'b0;
      win_load    = 1'b0;
      win_val     = T_W'(TIMEOUT_CYC);
      chg_load    = 1'b0;
      // load of 1 makes the first change pulse land on the cycle after entry
      chg_val     = T_W'(1);

      case (state)
         ST_IDLE: begin
            if (coin_evt) begin
               credit_nx = CREDIT_W'(coin_units);
               state_nx  = ST_COLLECT;
               win_load  = 1'b1;
            end
         end

         ST_COLLECT: begin
            if (coin_evt) begin
               if (credit_sum[CREDIT_W])
                  reject_nx = 1'b1;
               else
                  credit_nx = credit_sum[CREDIT_W-1:0];
            end
            if (cancel_s) begin
               state_nx = ST_REFUND;
               chg_load = 1'b1;
            end else if (press_s && (credit >= PRICE_C)) begin
               state_nx    = ST_VEND;
               dispense_nx = 1'b1;
            end else if (coin_evt) begin
               win_load = 1'b1;
            end else if (win_expire) begin
               timeout_nx = 1'b1;
               state_nx   = ST_REFUND;
               chg_load   = 1'b1;
            end
         end

         ST_VEND: begin
            credit_nx = credit - PRICE_C;
            if (credit > PRICE_C) begin
               state_nx = ST_REFUND;
               chg_load = 1'b1;
            end else begin
               state_nx = ST_DONE;
               win_load = 1'b1;
               win_val  = T_W'(TIMEOUT_CYC - 1);
            end
         end

         ST_REFUND: begin
            if (chg_expire) begin
               change_nx = 1'b1;
               credit_nx = credit - CREDIT_W'(1);
               chg_load  = 1'b1;
               chg_val   = T_W'(CHANGE_CYC);
               if (credit == CREDIT_W'(1)) begin
                  state_nx = ST_DONE;
                  win_load = 1'b1;
                  win_val  = T_W'(TIMEOUT_CYC - 1);
               end
            end
         end

         ST_DONE: begin
            // window is loaded one short so the timeout cycle is still DONE
            if (timeout)
               state_nx = ST_IDLE;
            else if (win_expire)
               timeout_nx = 1'b1;
         end

         default: state_nx = ST_IDLE;
      endcase

      if (coin_evt && ((state == ST_VEND) || (state == ST_REFUND) || (state == ST_DONE)))
         reject_nx = 1'b1;

      busy_nx = (state_nx == ST_VEND) || (state_nx == ST_REFUND) || (state_nx == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         credit       <= '0;
         timeout      <= 1'b0;
         dispense     <= 1'b0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         busy         <= 1'b0;
         coin_prev    <= 1'b0;
      end else begin
         state        <= state_nx;
         credit       <= credit_nx;
         timeout      <= timeout_nx;
         dispense     <= dispense_nx;
         change_pulse <= change_nx;
         coin_reject  <= reject_nx;
         busy         <= busy_nx;
         coin_prev    <= (coin_units != 3'd0);
      end
   end

endmodule
